seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 8-digit seven-segment display. It owns the shared segment path (`svn_dcdr` input nibble and decimal-point input) and the eight active-low anode lines, and gives each digit a fixed slot. It inserts a blanking guard at every slot boundary to cover the decoder's one-cycle register latency and to suppress ghosting. A host loads a new 32-bit display word through a valid/ready handshake; the word is committed only at a frame boundary, so a frame never shows a mix of old and new data.

---
 rtl/seg_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit seven-segment display.
//
// Each digit owns a slot of SCAN_PERIOD cycles. The first GUARD cycles of every slot keep all
// anodes off, so the downstream decoder's registered segments settle before an anode selects
// the digit. A host loads a new display word through a one-entry valid/ready buffer. The
// buffered word moves into the active registers only at a frame boundary (slot 7 -> slot 0),
// so a frame never mixes old and new data.
//
// Ports
//   sys_clk     : system clock
//   sys_rst_n   : asynchronous active-low reset
//   wr_en       : host write request
//   wr_data     : eight hex nibbles, nibble i drives digit i
//   wr_dp       : per-digit decimal point, active high
//   wr_mask     : per-digit enable, 1 = digit may light
//   wr_ready    : pending buffer is empty and a write can be taken
//   digit       : nibble to the segment decoder
//   dp          : decimal point to the segment decoder, active high
//   AN          : anode drive, active low
//   frame_done  : one-cycle pulse following each frame boundary
module seg_scan_ctrl #(
  parameter logic [27:0] SCAN_PERIOD = 28'd100_000,
  parameter logic [7:0]  GUARD       = 8'd4,
  parameter logic        LZ_BLANK    = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  wr_mask,
  output logic        wr_ready,
  output logic [3:0]  digit,
  output logic        dp,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam logic [27:0] LastCnt  = SCAN_PERIOD - 28'd1;
  localparam logic [27:0] GuardCnt = {20'd0, GUARD};

  // Scan position
  logic        run_q, run_d;
  logic [27:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;

  // Active display content
  logic [31:0] act_data_q, act_data_d;
  logic [7:0]  act_dp_q, act_dp_d;
  logic [7:0]  act_mask_q, act_mask_d;

  // One-entry pending buffer
  logic [31:0] pend_data_q, pend_data_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic [7:0]  pend_mask_q, pend_mask_d;
  logic        pend_v_q, pend_v_d;

  // Registered outputs
  logic [3:0]  digit_q, digit_d;
  logic        dp_q, dp_d;
  logic [7:0]  an_q, an_d;
  logic        frame_done_q, frame_done_d;

  // Decoded events
  logic       slot_end;
  logic       frame_edge;
  logic       slot_start;
  logic       guard_hit;
  logic       wr_accept;
  logic       commit;
  logic [7:0] nz;
  logic [7:0] lit;

  // nz[i] is set when any nibble or dp bit at position i or above is non-zero; a digit with
  // nz clear is a leading zero.
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    nz     = '0;
    for (int i = 7; i >= 0; i--) begin
      any_nz = any_nz | (|act_data_q[4*i +: 4]) | act_dp_q[i];
      nz[i]  = any_nz;
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < 8; i++) begin
      lit[i] = act_mask_q[i] & ((i == 0) | ~LZ_BLANK | nz[i]);
    end
  end

  always_comb begin
    // Scan timing. The first edge after reset is the start of slot 0 without advancing cnt.
    slot_end   = run_q && (cnt_q == LastCnt);
    frame_edge = slot_end && (idx_q == 3'd7);
    slot_start = !run_q || slot_end;
    guard_hit  = run_q && !slot_end && ((cnt_q + 28'd1) == GuardCnt);

    run_d = 1'b1;
    cnt_d = slot_start ? 28'd0 : cnt_q + 28'd1;
    idx_d = slot_end ? idx_q + 3'd1 : idx_q;

    // Handshake and frame-boundary commit; accept and commit are mutually exclusive because
    // accept requires an empty buffer.
    wr_accept = wr_en && !pend_v_q;
    commit    = frame_edge && pend_v_q;

    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_mask_d  = act_mask_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_mask_d = pend_mask_q;
    pend_v_d    = pend_v_q;

    if (commit) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
      act_mask_d = pend_mask_q;
      pend_v_d   = 1'b0;
    end else if (wr_accept) begin
      pend_data_d = wr_data;
      pend_dp_d   = wr_dp;
      pend_mask_d = wr_mask;
      pend_v_d    = 1'b1;
    end

    // Segment path loads at slot start from the post-commit content; anodes stay dark until
    // the guard interval has passed.
    digit_d      = digit_q;
    dp_d         = dp_q;
    an_d         = an_q;
    frame_done_d = frame_edge;

    if (slot_start) begin
      digit_d = act_data_d[{idx_d, 2'b00} +: 4];
      dp_d    = act_dp_d[idx_d];
      an_d    = 8'hFF;
    end else if (guard_hit) begin
      an_d = lit[idx_q] ? ~(8'h01 << idx_q) : 8'hFF;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q        <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_mask_q   <= 8'hFF;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_mask_q  <= '0;
      pend_v_q     <= 1'b0;
      digit_q      <= '0;
      dp_q         <= 1'b0;
      an_q         <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_mask_q   <= act_mask_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_mask_q  <= pend_mask_d;
      pend_v_q     <= pend_v_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready   = ~pend_v_q;
  assign digit      = digit_q;
  assign dp         = dp_q;
  assign AN         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with SCAN_PERIOD=16, GUARD=2. A frame-level model tracks the
// number of edges since reset release and derives slot, phase, active word and pending buffer
// with plain arithmetic; every cycle's outputs are compared against it.
module tb_seg_scan_ctrl;

  localparam int Sp    = 16;
  localparam int Gd    = 2;
  localparam int Frame = 8 * Sp;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic [7:0]  wr_mask;
  logic        wr_ready;
  logic [3:0]  digit;
  logic        dp;
  logic [7:0]  AN;
  logic        frame_done;

  seg_scan_ctrl #(
    .SCAN_PERIOD(28'd16),
    .GUARD      (8'd2),
    .LZ_BLANK   (1'b1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .wr_mask   (wr_mask),
    .wr_ready  (wr_ready),
    .digit     (digit),
    .dp        (dp),
    .AN        (AN),
    .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int          k;
  bit          started;
  logic [31:0] m_data;
  logic [7:0]  m_dp, m_mask;
  logic [31:0] p_data;
  logic [7:0]  p_dp, p_mask;
  bit          p_v;
  bit          m_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at k=%0d: got %h expected %h", tag, k, obs, exp);
  endtask

  function automatic bit model_lit(input int s);
    if (m_mask[s] == 1'b0) return 1'b0;
    if (s == 0) return 1'b1;
    return ((m_data >> (4 * s)) != 0) || ((m_dp >> s) != 0);
  endfunction

  task automatic model_reset();
    started = 0;
    k       = 0;
    m_data  = 32'h0;
    m_dp    = 8'h00;
    m_mask  = 8'hFF;
    p_v     = 0;
    m_fd    = 0;
  endtask

  task automatic model_edge();
    bit boundary;
    if (!started) begin
      started = 1;
      k       = 0;
    end else begin
      k++;
    end
    boundary = (k > 0) && (k % Frame == 0);
    if (boundary && p_v) begin
      m_data = p_data;
      m_dp   = p_dp;
      m_mask = p_mask;
      p_v    = 0;
    end else if (wr_en && !p_v) begin
      p_data = wr_data;
      p_dp   = wr_dp;
      p_mask = wr_mask;
      p_v    = 1;
    end
    m_fd = boundary;
  endtask

  task automatic check_outputs();
    int         s, c;
    logic [7:0] exp_an;
    s = (k / Sp) % 8;
    c = k % Sp;
    if (c < Gd) exp_an = 8'hFF;
    else exp_an = model_lit(s) ? ~(8'h01 << s) : 8'hFF;
    check("AN", {24'd0, AN}, {24'd0, exp_an});
    check("digit", {28'd0, digit}, (m_data >> (4 * s)) & 32'hF);
    check("dp", {31'd0, dp}, {31'd0, m_dp[s]});
    check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    check("wr_ready", {31'd0, wr_ready}, {31'd0, !p_v});
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [31:0] d, input logic [7:0] p, input logic [7:0] m);
    wr_en   = 1'b1;
    wr_data = d;
    wr_dp   = p;
    wr_mask = m;
    step();
    wr_en = 1'b0;
  endtask

  // Called just after a sampling point, clear of any clock edge.
  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_AN", {24'd0, AN}, 32'hFF);
    check("rst_digit", {28'd0, digit}, 32'h0);
    check("rst_dp", {31'd0, dp}, 32'h0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'h1);
    check("rst_frame_done", {31'd0, frame_done}, 32'h0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    wr_en     = 1'b0;
    wr_data   = '0;
    wr_dp     = '0;
    wr_mask   = '0;
    sys_rst_n = 1'b1;
    p_data    = '0;
    p_dp      = '0;
    p_mask    = '0;
    #2;
    do_reset();

    // Reset content: digit 0 lit, higher digits leading-zero blanked
    idle(Frame + 10);

    // Basic write
    wr(32'h1234_5678, 8'h00, 8'hFF);
    idle(2 * Frame);

    // Back-pressure: second write lands while the buffer is full
    wr(32'hAAAA_AAAA, 8'h00, 8'hFF);
    wr(32'hBBBB_BBBB, 8'h00, 8'hFF);
    idle(2 * Frame);

    // Leading-zero blanking, dp keeping a zero digit alive, mask
    wr(32'h0000_0042, 8'h00, 8'hFF);
    idle(2 * Frame);
    wr(32'h0000_0042, 8'h20, 8'hFF);
    idle(2 * Frame);
    wr(32'h0000_0042, 8'h20, 8'hFE);
    idle(2 * Frame);

    // wr_en held high: one word per frame
    for (int i = 0; i < 3 * Frame; i++) begin
      wr_en   = 1'b1;
      wr_data = $urandom;
      wr_dp   = 8'($urandom);
      wr_mask = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    idle(Frame);

    // Reset mid-frame with a pending word
    idle(37);
    wr(32'hDEAD_BEEF, 8'hFF, 8'hFF);
    idle(5);
    do_reset();
    idle(2 * Frame);

    // Write accepted on the edge just before the boundary
    for (int i = 0; i < Frame && (k % Frame) != Frame - 2; i++) step();
    check("align", k % Frame, Frame - 2);
    wr(32'h9876_543C, 8'h01, 8'hFF);
    idle(Frame + 4);

    // Randomized traffic with varied leading-zero depth, dp and mask
    for (int i = 0; i < 10 * Frame; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        wr_en   = 1'b1;
        wr_data = $urandom >> (4 * $urandom_range(0, 8));
        wr_dp   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        wr_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;
    idle(Frame);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
